uart_baud_ctrl: RTL
===================

# uart_baud_ctrl

Baud-rate controller for the UART. It owns the divisor counter and generates a 1-cycle oversample tick, a TX bit tick, and an RX mid-bit sample tick. Divisor reprogramming from the APB register file is deferred until both TX and RX are idle, so a frame in flight never changes rate. It sits between the UART register block and the TX/RX shift engines.

## Interface
- `DIV_W`, default 11: divisor width.
- `OVS`, default 16: oversample ticks per bit; must be a power of 2, ≥4.
- `DEFAULT_DIV`, default 650: divisor loaded at reset.
- `MIN_DIV`, default 1: smallest legal divisor.

- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: tick generation on/off.
- `cfg_wr`, in, 1: 1-cycle divisor write strobe.
- `cfg_div`, in, DIV_W: divisor written with `cfg_wr`.
- `busy_tx`, in, 1: TX frame in progress.
- `busy_rx`, in, 1: RX frame in progress.
- `rx_resync`, in, 1: RX start-bit edge. This port exists only with `UART_BAUD_RXSYNC_EN`.
- `os_tick`, out, 1: oversample tick, 1-cycle pulse.
- `tx_bit_tick`, out, 1: TX bit boundary pulse.
- `rx_mid_tick`, out, 1: RX mid-bit sample pulse.
- `cur_div`, out, DIV_W: divisor in use.
- `cfg_pending`, out, 1: a write is waiting to be applied.
- `cfg_err`, out, 1: sticky flag; the last write was illegal.

## Operation
- **Reset values:**
  - `cur_div` = DEFAULT_DIV.
  - All counters = 0.
  - `os_tick`, `tx_bit_tick`, `rx_mid_tick`, `cfg_pending`, `cfg_err` = 0.
  - The state machine is in OFF.
- **States:**
  - OFF (`enable`=0): counters held at 0 and all ticks 0. Goes to RUN when `enable`=1.
  - RUN: counting.
  - HOLD: counting, with a shadow divisor waiting to be applied.
  - RUN or HOLD go to OFF when `enable`=0. A pending shadow is kept and applied at the next entry to RUN.
- **Divisor counter:**
  - `cnt` counts 0..`cur_div`, then wraps to 0.
  - `os_tick` is registered and is 1 in the cycle after the edge where `cnt` wraps.
  - Tick period is `cur_div`+1 cycles.
- **Phase counter:**
  - `ph` is log2(OVS) bits wide and increments on each `os_tick`, wrapping at OVS.
  - `tx_bit_tick` = `os_tick` when `ph` was OVS-1. It is coincident with that `os_tick`.
- **RX phase, macro off:**
  - `rx_mid_tick` = `os_tick` when `ph` was OVS/2-1.
- **Config write:**
  - If `cfg_div` < MIN_DIV: the write is ignored and `cfg_err` is set to 1.
  - Otherwise `cfg_err` is cleared to 0, and:
    - OFF, or RUN with `busy_tx`=`busy_rx`=0: applied on the next edge (`cur_div`, `cnt` and `ph` are updated as described under Apply).
    - Otherwise: `cfg_div` is stored in the shadow, `cfg_pending`=1, state goes to HOLD.
- **Apply from HOLD:** on the first cycle with `busy_tx`=`busy_rx`=0:
  - `cur_div` takes the shadow value.
  - `cnt`=0, `ph`=0.
  - `cfg_pending`=0, state goes to RUN.
  - No tick is issued in the apply cycle.
- **Simultaneous events:**
  - A `cfg_wr` during HOLD overwrites the shadow (last writer wins).
  - `cfg_wr` in the same cycle as an apply: the new write wins; it is applied if idle, otherwise stored.
  - `busy_*` rising in the same cycle as `cfg_wr` blocks that write, which goes to HOLD.
- **Reset mid-operation:** all state returns to reset values immediately; any shadow is discarded.

## Timing
- From `enable` rising (sampled at edge 0), the first `os_tick` is high in the cycle after edge `cur_div`+1.
- A write that is applied immediately takes effect at the next edge. The first tick after it arrives `cfg_div`+1 cycles later.
- `cfg_pending` and `cfg_err` are registered: they are visible 1 cycle after `cfg_wr`.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro `UART_BAUD_RXSYNC_EN`.
- **Defined:**
  - Adds the `rx_resync` port and a separate RX phase counter `rph`.
  - When `rx_resync`=1 in RUN or HOLD: `cnt`=0 and `rph`=0 on the next edge. `ph` is unaffected.
  - `rx_mid_tick` = `os_tick` when `rph` was OVS/2-1. This gives the first pulse on the (OVS/2)th `os_tick` after the resync, then every OVS ticks.
  - `rx_resync` takes priority over the normal `cnt` increment. If it coincides with an apply, the apply wins.
- **Undefined:** no `rx_resync` port and no `rph`; `rx_mid_tick` is derived from the shared `ph`.

## Test plan
1. Reset, `enable`=1, then write `cfg_div`=3 while idle. Required: `cur_div`=3; `os_tick` every 4 cycles; with OVS=16, `tx_bit_tick` every 64 cycles; `rx_mid_tick` 32 cycles after each `tx_bit_tick`.
2. With `busy_tx`=1, write 5. Required: `cfg_pending`=1 and `cur_div` unchanged. Drop `busy_tx`; the next cycle `cur_div`=5, `cfg_pending`=0, and the tick period is 6.
3. In HOLD, write 7 then 9, then go idle. Required: `cur_div`=9.
4. Write 0 with MIN_DIV=1. Required: `cfg_err`=1 and `cur_div` unchanged. Then write 4. Required: `cfg_err`=0.
5. Assert `reset` mid-HOLD. Required: `cur_div`=650, `cfg_pending`=0, all ticks 0.
6. With `UART_BAUD_RXSYNC_EN` and `cur_div`=3, pulse `rx_resync`. Required: `rx_mid_tick` 32 cycles after the resync edge; `tx_bit_tick` cadence is relative to the `ph` count.

Source files
------------

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: UART baud-rate controller.
// Owns the divisor counter and produces the oversample tick, the TX bit tick
// and the RX mid-bit tick. A divisor write arriving while a frame is in flight
// is parked in a shadow register and applied once TX and RX are both idle.
// Optional build macro UART_BAUD_RXSYNC_EN adds the rx_resync input and a
// separate RX phase counter that is realigned on every RX start-bit edge.
module uart_baud_ctrl #(
   parameter int DIV_W       = 11,
   parameter int OVS         = 16,
   parameter int DEFAULT_DIV = 650,
   parameter int MIN_DIV     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_wr,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             busy_tx,
   input  logic             busy_rx,
`ifdef UART_BAUD_RXSYNC_EN
   input  logic             rx_resync,
`endif
   output logic             os_tick,
   output logic             tx_bit_tick,
   output logic             rx_mid_tick,
   output logic [DIV_W-1:0] cur_div,
   output logic             cfg_pending,
   output logic             cfg_err
);

   localparam int               PH_W    = $clog2(OVS);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVS - 1);
   localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OVS / 2 - 1);
   localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] DEF_V   = DIV_W'(DEFAULT_DIV);

   typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_HOLD} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] apply_div;
   logic [PH_W-1:0]  ph;
   logic             idle, wr_ok, wr_bad;
   logic             apply, store;
   logic             run_cnt, wrap, resync, rx_hit;

   assign idle    = !busy_tx && !busy_rx;
   assign wr_bad  = cfg_wr && (cfg_div < MIN_V);
   assign wr_ok   = cfg_wr && !wr_bad;
   // Counters only advance in RUN/HOLD while enabled; an apply restarts them.
   assign run_cnt = (state != ST_OFF) && enable && !apply;
   assign wrap    = run_cnt && !resync && (cnt == cur_div);

`ifdef UART_BAUD_RXSYNC_EN
   logic [PH_W-1:0] rph;
   assign resync = rx_resync;
   assign rx_hit = (rph == PH_MID);
`else
   assign resync = 1'b0;
   assign rx_hit = (ph == PH_MID);
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_OFF;
      else       state <= state_nxt;
   end

   // Next state plus apply/store decisions for the divisor.
   always_comb begin
      state_nxt = state;
      apply     = 1'b0;
      store     = 1'b0;
      apply_div = shadow;
      case (state)
         ST_OFF: begin
            // Nothing is in flight while off, so a legal write lands at once;
            // a parked shadow is applied on the way back into RUN.
            if (wr_ok) begin
               apply     = 1'b1;
               apply_div = cfg_div;
            end else if (enable && cfg_pending) begin
               apply = 1'b1;
            end
            state_nxt = enable ? ST_RUN : ST_OFF;
         end
         ST_RUN, ST_HOLD: begin
            // A fresh write always beats the shadow (last writer wins).
            if (wr_ok && idle) begin
               apply     = 1'b1;
               apply_div = cfg_div;
               state_nxt = ST_RUN;
            end else if (wr_ok) begin
               store     = 1'b1;
               state_nxt = ST_HOLD;
            end else if (state == ST_HOLD && idle && enable) begin
               apply     = 1'b1;
               state_nxt = ST_RUN;
            end
            if (!enable) state_nxt = ST_OFF;
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   // Divisor in use, shadow divisor and the pending flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_div     <= DEF_V;
         shadow      <= '0;
         cfg_pending <= 1'b0;
      end else begin
         if (apply) cur_div <= apply_div;
         if (store) shadow  <= cfg_div;
         if (apply)      cfg_pending <= 1'b0;
         else if (store) cfg_pending <= 1'b1;
      end
   end

   // Sticky error: set by an illegal write, cleared by the next legal one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cfg_err <= 1'b0;
      else if (wr_bad) cfg_err <= 1'b1;
      else if (wr_ok)  cfg_err <= 1'b0;
   end

   // Divisor counter, shared phase counter and the registered tick pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         ph          <= '0;
         os_tick     <= 1'b0;
         tx_bit_tick <= 1'b0;
         rx_mid_tick <= 1'b0;
      end else begin
         os_tick     <= 1'b0;
         tx_bit_tick <= 1'b0;
         rx_mid_tick <= 1'b0;
         if (!run_cnt) begin
            cnt <= '0;
            ph  <= '0;
         end else if (resync) begin
            // Realign bit timing to the start edge; ph keeps TX cadence.
            cnt <= '0;
         end else if (wrap) begin
            cnt         <= '0;
            ph          <= ph + PH_ONE;
            os_tick     <= 1'b1;
            tx_bit_tick <= (ph == PH_LAST);
            rx_mid_tick <= rx_hit;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

`ifdef UART_BAUD_RXSYNC_EN
   // RX phase counter, restarted on every start-bit edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  rph <= '0;
      else if (!run_cnt || resync) rph <= '0;
      else if (wrap)              rph <= rph + PH_ONE;
   end
`endif

endmodule
